accum_arbiter: RTL
==================

# accum_arbiter

Two-requester burst controller for the 16-bit sample accumulator. Arbitrates round-robin between two sample sources and grants the shared accumulator to one burst at a time. For each burst it clears the accumulator, sums a programmed number of handshaken 8-bit samples, and publishes the total with a per-requester completion pulse. Sits between the chip's input sources (dedicated inputs and bidirectional IOs) and the accumulator result that drives the output pins.

## Interface
Parameters:
- DATA_W, 8, sample width; zero-extended before adding.
- ACC_W, 16, accumulator and result width.
- LEN_W, 10, burst-length field width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  2  per-requester burst request (level); sampled only in IDLE.
- len0, len1  in  LEN_W  burst length in samples for requester 0/1; sampled on the grant edge.
- data0, data1  in  DATA_W  sample from requester 0/1.
- valid  in  2  per-requester sample valid.
- ready  out  2  accumulator accepting from that requester.
- gnt  out  2  one-hot grant; 0 when idle.
- busy  out  1  burst in progress (ACCUM or DONE).
- done  out  2  one-cycle completion pulse for the served requester.
- result  out  ACC_W  total of the last completed burst; held until the next completion.

## Operation
- FSM states: IDLE, ACCUM, DONE. Outputs are Moore-decoded from registered state and owner.
- IDLE: if any req bit is set, the arbiter picks the owner. Then: acc←0, count←len[owner], last←owner.
  - If len is nonzero, go to ACCUM.
  - If len is 0, go directly to DONE.
- ACCUM: ready[owner]=1 and gnt[owner]=1. On valid[owner]&ready[owner]: acc←acc+zext(data[owner]) and count←count−1. The handshake with count==1 moves to DONE.
- DONE: lasts one cycle with done[owner]=1. result was loaded with the final acc on the DONE entry edge. Next state is IDLE.
- Round-robin:
  - A single requester always wins.
  - If both request, the winner is the one ≠ last.
  - last resets to 1, so requester 0 wins the first contest.
- The non-owner's valid and data are ignored, and its ready is 0. Dropping req mid-burst has no effect; the burst runs to completion.
- len=0 completes with result=0 and no handshakes.
- Arithmetic: by default, sums wrap modulo 2^ACC_W.

## Timing
- Reset values: gnt=0, ready=0, done=0, busy=0, result=0, acc=0, state=IDLE, last=1.
- Reset mid-burst aborts immediately. result returns to 0 and no done pulse is issued.
- Request sampled at edge E0 → gnt, ready and busy are high after E0.
- With valid continuously high, samples are accepted at E1..EN. done is high during the cycle after EN, with result already updated.
- DONE→IDLE at E(N+1). The earliest next grant edge is E(N+2), so there is one IDLE cycle between bursts.
- Stalls (valid low) extend ACCUM one cycle per stalled cycle. There is no timeout.

## Configuration
- ACCUM_SAT_EN defined: each add that would exceed 2^ACC_W−1 clamps acc to all-ones. Further adds hold at all-ones.
- ACCUM_SAT_EN undefined: modular wrap. No saturation logic is compiled.

## Structure
- Package accum_pkg:
  - state enum (IDLE/ACCUM/DONE)
  - ACC_W, DATA_W, LEN_W defaults
  - reset constant for last (1)
- Sub-module rr_arb2: combinational two-way round-robin pick from req[1:0] and last. It outputs a one-hot winner and an any-request flag. The pointer register stays in accum_arbiter.

## Test plan
- Reset, then req=2'b01, len0=3, data0=0x10/0x20/0x30 with valid always high → gnt=01 for 4 cycles, done=01 one cycle, result=0x0060.
- req=2'b11 held across three bursts (len=1, data0=0x01, data1=0x02) → owners served in order 0,1,0; results 0x0001, 0x0002, 0x0001; one IDLE cycle between bursts.
- Requester 1 burst, len1=2, valid1 toggling 1,0,0,1; valid0=1 throughout with data0=0xFF → ready0 never asserted, done=10 after 4 ACCUM cycles, result=data1 sum only.
- len0=0 → no ready, done=01 one cycle after grant, result=0x0000.
- len0=300, data0=0xFF → result=0x2AD4 without ACCUM_SAT_EN; result=0xFFFF with ACCUM_SAT_EN.
- rst_n pulled low after the 2nd sample of a len=5 burst → all outputs 0 asynchronously, no done pulse; a fresh request after release restarts from acc=0.

Source files
------------

// File: rtl/accum_pkg.sv
// accum_pkg: shared types and defaults for the accum_arbiter burst controller.
//   state_t       FSM encoding (IDLE / ACCUM / DONE)
//   *_W_DEF       default widths for sample, accumulator and burst length
//   LAST_RST      reset value of the round-robin pointer, so that requester 0
//                 wins the first contested arbitration
package accum_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;
  localparam int LEN_W_DEF  = 10;

  localparam logic LAST_RST = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick.
//   i_req   [1:0]  request vector
//   i_last         index of the most recently served requester
//   o_win   [1:0]  one-hot winner (0 when nothing is requested)
//   o_any          at least one request is present
// The pointer itself is owned by the caller.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_win,
  output logic       o_any
);

  assign o_any = |i_req;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    o_win = i_req;
    // On a contest the requester not served last time wins.
    if (&i_req) begin
      o_win = i_last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/accum_arbiter.sv
// accum_arbiter: two-requester burst controller for the sample accumulator.
// Grants the accumulator to one requester at a time (round-robin), clears it,
// sums len[owner] handshaken samples and publishes the total on result with a
// one-cycle done pulse for the served requester.
//   clk, rst_n        clock, asynchronous active-low reset
//   req   [1:0]       burst request levels, sampled only in IDLE
//   len0/len1         burst length per requester, captured on the grant edge
//   data0/data1       samples, zero-extended before adding
//   valid [1:0]       sample valid per requester
//   ready [1:0]       accumulator accepting from that requester
//   gnt   [1:0]       one-hot grant, 0 when idle
//   busy              burst in progress (ACCUM or DONE)
//   done  [1:0]       completion pulse for the served requester
//   result            total of the last completed burst
// Build option: define ACCUM_SAT_EN to clamp the sum at all-ones instead of
// wrapping modulo 2^ACC_W.
module accum_arbiter
  import accum_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [LEN_W-1:0]  len0,
  input  logic [LEN_W-1:0]  len1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic [1:0]        valid,
  output logic [1:0]        ready,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic [1:0]        done,
  output logic [ACC_W-1:0]  result
);

  state_t             r_state;
  state_t             w_next;
  logic               r_last;     // owner of the current or most recent burst
  logic [ACC_W-1:0]   r_acc;
  logic [LEN_W-1:0]   r_count;    // samples still to accept
  logic [ACC_W-1:0]   r_result;

  logic [1:0]         w_win;
  logic               w_any;
  logic [LEN_W-1:0]   w_len;
  logic [DATA_W-1:0]  w_data;
  logic               w_fire;
  logic               w_last_sample;
  logic [ACC_W-1:0]   w_acc_next;

  rr_arb2 u_arb (
    .i_req  (req),
    .i_last (r_last),
    .o_win  (w_win),
    .o_any  (w_any)
  );

  assign w_len  = w_win[1] ? len1 : len0;
  assign w_data = r_last ? data1 : data0;

  // ready[owner] is high for exactly the ACCUM state, so the handshake only
  // needs the owner's valid.
  assign w_fire        = (r_state == ACCUM) && valid[r_last];
  assign w_last_sample = w_fire && (r_count == LEN_W'(1));

`ifdef ACCUM_SAT_EN
  logic [ACC_W:0] w_sum;
  assign w_sum      = {1'b0, r_acc} + (ACC_W + 1)'(w_data);
  assign w_acc_next = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
`else
  assign w_acc_next = r_acc + ACC_W'(w_data);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    ready  = 2'b00;
    gnt    = 2'b00;
    done   = 2'b00;
    busy   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) w_next = (w_len == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        ready[r_last] = 1'b1;
        gnt[r_last]   = 1'b1;
        busy          = 1'b1;
        if (w_last_sample) w_next = DONE;
      end
      DONE: begin
        gnt[r_last]  = 1'b1;
        done[r_last] = 1'b1;
        busy         = 1'b1;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last   <= LAST_RST;
      r_acc    <= '0;
      r_count  <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_last  <= w_win[1];
            r_acc   <= '0;
            r_count <= w_len;
            // A zero-length burst enters DONE directly with an empty sum.
            if (w_len == '0) r_result <= '0;
          end
        end
        ACCUM: begin
          if (w_fire) begin
            r_acc   <= w_acc_next;
            r_count <= r_count - LEN_W'(1);
            if (w_last_sample) r_result <= w_acc_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;

endmodule
